// File: rtl/matrix_pixel_streamer.sv
// rtl/matrix_pixel_streamer.sv - snapshots a ROWSxCOLS occupancy matrix and streams one GRB word per LED
// Optional feature: define SERPENTINE_EN to reverse odd rows for zig-zag panel wiring.
module matrix_pixel_streamer #(
  parameter int          ROWS       = 16,
  parameter int          COLS       = 16,
  parameter logic [23:0] ON_COLOR   = 24'h001000,
  parameter logic [23:0] OFF_COLOR  = 24'h000000,
  parameter int          GAP_CYCLES = 3000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic [ROWS-1:0][COLS-1:0]  matrix,
  output logic [23:0]                pix_data,
  output logic                       pix_valid,
  input  logic                       pix_ready,
  output logic                       frame_start,
  output logic                       frame_done,
  output logic                       busy
);

  localparam int NPIX  = ROWS * COLS;
  localparam int IDX_W = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPIX - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LATCH, STREAM, GAP} state_t;

  state_t                      state_q, state_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [GAP_W-1:0]            gap_cnt_q, gap_cnt_d;
  logic [ROWS-1:0][COLS-1:0]   shadow_q, shadow_d;
  logic                        valid_q, valid_d;
  logic                        start_q, start_d;

  logic                        handshake;
  logic [ROW_W-1:0]            row;
  logic [COL_W-1:0]            c;
  logic [COL_W-1:0]            col;

  assign handshake = valid_q & pix_ready;

  always_comb begin
    row = ROW_W'(32'(idx_q) / COLS);
    c   = COL_W'(32'(idx_q) % COLS);
    col = c;
`ifdef SERPENTINE_EN
    if (row[0]) col = COL_W'(COLS - 1) - c;
`endif
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    gap_cnt_d = gap_cnt_q;
    shadow_d  = shadow_q;
    valid_d   = 1'b0;
    start_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) begin
          state_d = LATCH;
          start_d = 1'b1;
        end
      end
      LATCH: begin
        shadow_d = matrix;
        idx_d    = '0;
        state_d  = STREAM;
        valid_d  = 1'b1;
      end
      STREAM: begin
        valid_d = 1'b1;
        if (handshake) begin
          if (idx_q == LAST_IDX) begin
            // idx parks on the last pixel; LATCH rewinds it for the next frame
            state_d   = GAP;
            gap_cnt_d = '0;
            valid_d   = 1'b0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d = '0;
          if (en) begin
            state_d = LATCH;
            start_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      gap_cnt_q <= '0;
      shadow_q  <= '0;
      valid_q   <= 1'b0;
      start_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      gap_cnt_q <= gap_cnt_d;
      shadow_q  <= shadow_d;
      valid_q   <= valid_d;
      start_q   <= start_d;
    end
  end

  // Gated by valid so reset and idle both present an all-zero word
  assign pix_data    = valid_q ? (shadow_q[row][col] ? ON_COLOR : OFF_COLOR) : 24'h000000;
  assign pix_valid   = valid_q;
  assign frame_start = start_q;
  assign frame_done  = handshake & (idx_q == LAST_IDX);
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_matrix_pixel_streamer.sv
// tb/tb_matrix_pixel_streamer.sv - randomized self-checking bench for matrix_pixel_streamer
// Honours SERPENTINE_EN the same way as the design build.
module tb_matrix_pixel_streamer;

  localparam int          ROWS = 16;
  localparam int          COLS = 16;
  localparam int          NPIX = ROWS * COLS;
  localparam logic [23:0] ON   = 24'h001000;
  localparam logic [23:0] OFF  = 24'h000000;
  localparam int          GAP  = 3000;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic                      en;
  logic [ROWS-1:0][COLS-1:0] matrix;
  logic [23:0]               pix_data;
  logic                      pix_valid;
  logic                      pix_ready;
  logic                      frame_start;
  logic                      frame_done;
  logic                      busy;

  logic [ROWS-1:0][COLS-1:0] snap;
  int n_pass  = 0;
  int n_total = 0;
  int nhs, first_hs, last_hs, first_on, waited;

  matrix_pixel_streamer #(
    .ROWS(ROWS), .COLS(COLS), .ON_COLOR(ON), .OFF_COLOR(OFF), .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .matrix(matrix),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .frame_start(frame_start), .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: pixel k is the snapshot cell at row k/COLS, column k%COLS (mirrored on odd rows when serpentine)
  function automatic logic [23:0] exp_pix(input logic [ROWS-1:0][COLS-1:0] s, input int k);
    int r = k / COLS;
    int cc = k % COLS;
`ifdef SERPENTINE_EN
    if (r % 2 == 1) cc = COLS - 1 - cc;
`endif
    return s[r][cc] ? ON : OFF;
  endfunction

  task automatic rand_matrix();
    for (int r = 0; r < ROWS; r++) matrix[r] = COLS'($urandom);
  endtask

  task automatic wait_start();
    waited = -1;
    for (int i = 0; i < GAP + 20; i++) begin
      @(negedge clk); #1;
      if (frame_start) begin
        waited = i;
        snap   = matrix;
        break;
      end
    end
    chk("frame_start_seen", 32'(waited >= 0), 1);
  endtask

  // mode 0: ready always high; mode 1: ready alternates 1,0
  // ev_kind 1: matrix all ones, 2: en low, 3: async reset -- applied when ev_idx pixels are done
  task automatic stream(input int mode, input int ev_kind, input int ev_idx);
    int          cyc = 0;
    logic [23:0] held = '0;
    bit          stalled = 0;
    bit          hs;
    nhs = 0; first_hs = -1; last_hs = -1; first_on = -1;
    while (nhs < NPIX && cyc < 4 * NPIX) begin
      @(negedge clk);
      pix_ready = (mode == 0) || (cyc % 2 == 0);
      if (nhs == ev_idx) begin
        if (ev_kind == 1) matrix = '1;
        if (ev_kind == 2) en = 1'b0;
        if (ev_kind == 3) begin
          #2 rst_n = 1'b0;
          #1;
          chk("abort_valid", 32'(pix_valid), 0);
          chk("abort_data", 32'(pix_data), 0);
          chk("abort_busy", 32'(busy), 0);
          return;
        end
      end
      #1;
      chk("stream_valid", 32'(pix_valid), 1);
      if (stalled) chk("stall_hold", 32'(pix_data), 32'(held));
      hs = pix_valid && pix_ready;
      chk($sformatf("frame_done@%0d", nhs), 32'(frame_done), 32'(hs && nhs == NPIX - 1));
      if (hs) begin
        chk($sformatf("pixel%0d", nhs), 32'(pix_data), 32'(exp_pix(snap, nhs)));
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
        if (first_on < 0 && pix_data == ON) first_on = nhs;
        nhs++;
      end
      stalled = !pix_ready;
      held    = pix_data;
      cyc++;
    end
  endtask

  initial begin
    int busy_cnt, bad_valid;
    rst_n = 1'b0; en = 1'b1; pix_ready = 1'b1; matrix = '0; snap = '0;

    // reset state with en and ready both high
    repeat (3) @(negedge clk);
    #1;
    chk("rst_valid", 32'(pix_valid), 0);
    chk("rst_data", 32'(pix_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_start", 32'(frame_start), 0);
    chk("rst_done", 32'(frame_done), 0);

    // single cell [0][0], ready high
    matrix[0][0] = 1'b1;
    rst_n = 1'b1;
    wait_start();
    chk("start_latency", 32'(waited), 0);
    stream(0, 0, -1);
    chk("single_hs", 32'(nhs), NPIX);
    chk("single_span", 32'(last_hs - first_hs + 1), NPIX);
    chk("single_first_on", 32'(first_on), 0);

    // serpentine probe: only [1][0]
    matrix = '0; matrix[1][0] = 1'b1;
    wait_start();
    stream(0, 0, -1);
`ifdef SERPENTINE_EN
    chk("serp_on_idx", 32'(first_on), 31);
`else
    chk("serp_on_idx", 32'(first_on), 16);
`endif

    // backpressure with random content
    rand_matrix();
    wait_start();
    stream(1, 0, -1);
    chk("bp_hs", 32'(nhs), NPIX);
    chk("bp_span", 32'(last_hs - first_hs + 1), 2 * NPIX - 1);

    // tear-free: matrix rewritten mid-frame, then the following frame shows it
    rand_matrix();
    wait_start();
    stream(0, 1, 10);
    chk("tear_hs", 32'(nhs), NPIX);
    wait_start();
    chk("ones_snapshot", 32'(snap == '1), 1);
    stream(0, 0, -1);
    chk("ones_hs", 32'(nhs), NPIX);

    // stop: en dropped mid-frame, frame and gap complete, then idle
    rand_matrix();
    wait_start();
    stream(0, 2, 100);
    chk("stop_hs", 32'(nhs), NPIX);
    busy_cnt = 0; bad_valid = 0;
    for (int i = 0; i < GAP + 50; i++) begin
      @(negedge clk); #1;
      if (!busy) break;
      busy_cnt++;
      if (pix_valid) bad_valid++;
    end
    chk("stop_gap_len", 32'(busy_cnt), GAP);
    chk("stop_gap_valid", 32'(bad_valid), 0);
    chk("stop_idle", 32'(busy), 0);

    // abort: async reset at idx 100, then a fresh frame from idx 0
    rand_matrix();
    matrix[0][0] = 1'b1;
    en = 1'b1;
    wait_start();
    stream(0, 3, 100);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_start();
    chk("restart_latency", 32'(waited), 0);
    stream(0, 0, -1);
    chk("restart_hs", 32'(nhs), NPIX);
    chk("restart_first_on", 32'(first_on), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
